// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with synchronous flush; the head reads as zero when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_entry_t             wdata_i,
  output fetch_entry_t             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + (PW+1)'(1);
    else if (pop_i && !push_i) count_d = count_q - (PW+1)'(1);
  end

  // When full, push and pop share a slot: the popped head is overwritten by the new entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, ROM addressing, and a fetch queue toward decode with redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       rom_addr,
  input  logic [INST_W-1:0] rom_out,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          push, pop;
  logic          q_full, q_empty;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_wdata, q_head;

  assign pop     = inst_valid & inst_ready;
  assign push    = !redirect_valid & (!q_full | pop);
  assign q_wdata = '{pc: pc_q, inst: rom_out};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc & 32'hFFFF_FFFC;
    else if (push)      pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (q_wdata),
    .rdata_o (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign rom_addr   = {2'b00, pc_q[31:2]};
  assign inst_valid = !q_empty;
  assign inst       = q_head.inst;
  assign inst_pc    = q_head.pc;

  a_count_bound : assert property (@(posedge clk) disable iff (rst) q_count <= QDEPTH_C);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, word} entries are queued and matched on each handshake.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr, rom_out, redirect_pc, inst, inst_pc;
  logic        redirect_valid, inst_valid, inst_ready;
  logic [31:0] rom_addr2, rom_out2, inst2, inst_pc2;
  logic        inst_valid2;

  int checks = 0;
  int errors = 0;
  fetch_entry_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'd0:   rom_word = 32'h002080B3;
      32'd1:   rom_word = 32'h40208033;
      default: rom_word = {a[15:0], 16'h0013} ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic fetch_entry_t exp_entry(input logic [31:0] pc);
    exp_entry = '{pc: pc, inst: rom_word({2'b00, pc[31:2]})};
  endfunction

  assign rom_out  = rom_word(rom_addr);
  assign rom_out2 = rom_word(rom_addr2);

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_out(rom_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .rom_addr(rom_addr2), .rom_out(rom_out2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .inst_ready(1'b1)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    sb.delete();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #3;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", inst_pc); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
    checks++; if (rom_addr2 !== 32'h3FFF_FFFF) begin errors++; $display("FAIL reset_rom_addr2 got %h want 3fffffff", rom_addr2); end
  endtask

  task automatic test_free_run();
    fetch_entry_t e;
    apply_reset();
    inst_ready = 1'b1;
    for (int unsigned k = 0; k < 6; k++) sb.push_back(exp_entry(32'(k * 4)));
    for (int unsigned k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if (!inst_valid || sb.size() == 0) begin
        errors++; $display("FAIL free_valid k=%0d got valid=%b sb=%0d", k, inst_valid, sb.size());
      end else begin
        e = sb.pop_front();
        if (inst !== e.inst || inst_pc !== e.pc) begin
          errors++; $display("FAIL free_entry got %h@%h want %h@%h", inst, inst_pc, e.inst, e.pc);
        end
      end
      checks++; if (rom_addr !== 32'(k + 1)) begin errors++; $display("FAIL free_rom_addr got %h want %h", rom_addr, k + 1); end
    end
  endtask

  task automatic test_stall_release();
    fetch_entry_t e;
    apply_reset();
    for (int unsigned k = 0; k < 4; k++) sb.push_back(exp_entry(32'(k * 4)));
    repeat (5) cycle();
    checks++; if (rom_addr !== 32'd2) begin errors++; $display("FAIL stall_rom_addr got %h want 2", rom_addr); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", inst_valid); end
    inst_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      checks++;
      if (!inst_valid || sb.size() == 0) begin
        errors++; $display("FAIL stall_valid k=%0d got valid=%b sb=%0d", k, inst_valid, sb.size());
      end else begin
        e = sb.pop_front();
        if (inst !== e.inst || inst_pc !== e.pc) begin
          errors++; $display("FAIL stall_entry got %h@%h want %h@%h", inst, inst_pc, e.inst, e.pc);
        end
      end
      cycle();
      checks++; if (rom_addr !== 32'(3 + k)) begin errors++; $display("FAIL full_pop_rom_addr got %h want %h", rom_addr, 3 + k); end
    end
  endtask

  task automatic test_redirect();
    fetch_entry_t e;
    apply_reset();
    repeat (2) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0022; inst_ready = 1'b1;
    cycle();
    redirect_valid = 1'b0; redirect_pc = '0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", inst_valid); end
    checks++; if (rom_addr !== 32'd8) begin errors++; $display("FAIL redir_rom_addr got %h want 8", rom_addr); end
    sb.delete();
    for (int unsigned k = 0; k < 3; k++) sb.push_back(exp_entry(32'h20 + 32'(k * 4)));
    for (int unsigned k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (!inst_valid || sb.size() == 0) begin
        errors++; $display("FAIL redir_target k=%0d got valid=%b sb=%0d", k, inst_valid, sb.size());
      end else begin
        e = sb.pop_front();
        if (inst !== e.inst || inst_pc !== e.pc) begin
          errors++; $display("FAIL redir_entry got %h@%h want %h@%h", inst, inst_pc, e.inst, e.pc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    cycle();
    checks++; if (inst_pc2 !== 32'hFFFF_FFFC || inst2 !== rom_word(32'h3FFF_FFFF)) begin
      errors++; $display("FAIL wrap_first got %h@%h want %h@fffffffc", inst2, inst_pc2, rom_word(32'h3FFF_FFFF)); end
    checks++; if (rom_addr2 !== 32'h0) begin errors++; $display("FAIL wrap_rom_addr got %h want 0", rom_addr2); end
    cycle();
    checks++; if (!inst_valid2 || inst_pc2 !== 32'h0 || inst2 !== 32'h002080B3) begin
      errors++; $display("FAIL wrap_second got %h@%h valid=%b want 002080b3@0", inst2, inst_pc2, inst_valid2); end
  endtask

  task automatic test_mid_reset();
    fetch_entry_t e;
    apply_reset();
    cycle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b want 1", inst_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL midrst_clear got valid=%b %h@%h want 0", inst_valid, inst, inst_pc); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL midrst_rom_addr got %h want 0", rom_addr); end
    cycle();
    rst = 1'b0; inst_ready = 1'b1;
    sb.delete();
    for (int unsigned k = 0; k < 2; k++) sb.push_back(exp_entry(32'(k * 4)));
    for (int unsigned k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (!inst_valid || sb.size() == 0) begin
        errors++; $display("FAIL midrst_restart k=%0d got valid=%b sb=%0d", k, inst_valid, sb.size());
      end else begin
        e = sb.pop_front();
        if (inst !== e.inst || inst_pc !== e.pc) begin
          errors++; $display("FAIL midrst_entry got %h@%h want %h@%h", inst, inst_pc, e.inst, e.pc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    fetch_entry_t e;
    apply_reset();
    for (int unsigned k = 0; k < 48; k++) sb.push_back(exp_entry(32'(k * 4)));
    for (int unsigned k = 0; k < 40; k++) begin
      inst_ready = 1'($urandom_range(0, 1));
      if (inst_valid && inst_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_underflow got entry %h@%h want none", inst, inst_pc);
        end else begin
          e = sb.pop_front();
          if (inst !== e.inst || inst_pc !== e.pc) begin
            errors++; $display("FAIL b2b_entry got %h@%h want %h@%h", inst, inst_pc, e.inst, e.pc);
          end
        end
      end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall_release();
    test_redirect();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage between the program counter and decode. It holds the PC, drives a word-indexed combinational instruction ROM, and captures each returned word with its PC into a small queue. The queue feeds decode over a valid/ready handshake and absorbs decode stalls without losing or re-fetching instructions. Branch and jump redirects flush the queue and reload the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset (byte address).
- `QDEPTH`, default 2: fetch-queue entries; must be a power of two and at least 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rom_addr`  out  32  ROM word index, equal to {2'b00, pc[31:2]}; combinational from the PC register.
- `rom_out`  in  32  instruction word returned combinationally by the ROM for `rom_addr`.
- `redirect_valid`  in  1  redirect request from execute, for a taken branch or a jump.
- `redirect_pc`  in  32  redirect target byte address; bits [1:0] are ignored and treated as 0.
- `inst_valid`  out  1  the queue head is valid.
- `inst`  out  32  instruction word at the queue head.
- `inst_pc`  out  32  byte PC of the queue-head instruction.
- `inst_ready`  in  1  decode accepts the head this cycle.

## Operation
- pop = inst_valid & inst_ready.
- push = !redirect_valid & (count < QDEPTH | pop).
- On push:
  - enqueue {pc, rom_out};
  - pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- No push and no redirect: pc holds, and `rom_addr` stays stable.
- Redirect (redirect_valid=1):
  - flush the queue, so count <= 0 and the pointers reset;
  - pc <= {redirect_pc[31:2], 2'b00};
  - no push this cycle;
  - a simultaneous pop counts as a completed handshake, and the flushed entries are discarded.
- Full queue with a simultaneous pop: the push proceeds and count is unchanged.
- Empty queue: inst_valid=0, and `inst` and `inst_pc` read as 0.
- Count arithmetic: count is $clog2(QDEPTH)+1 bits wide and never exceeds QDEPTH. Pointers wrap modulo QDEPTH.
- No illegal-instruction checks; words pass through unmodified.

## Timing
- Reset values (asynchronous, effective while rst=1):
  - pc=RESET_PC;
  - count=0, and read and write pointers = 0;
  - inst_valid=0, inst=0, inst_pc=0;
  - rom_addr={2'b00, RESET_PC[31:2]}.
- Latency: the word for a given PC appears at `inst` one cycle after that PC drives `rom_addr`, provided the queue was empty.
- Throughput: one instruction per cycle with inst_ready held at 1.
- After redirect: the first target instruction is valid 1 cycle after the redirect cycle, and the redirect cycle itself produces no output.
- Deassertion of rst: the first push happens on the first rising edge with rst=0.
- Reset mid-operation clears the queue immediately, so inst_valid drops combinationally with rst.

## Structure
- Shared package `fetch_pkg`:
  - typedef struct packed fetch_entry_t {logic [31:0] pc; logic [31:0] inst;};
  - localparam INST_W=32;
  - localparam NOP=32'h0000_0013.
- Sub-module `fetch_queue`: parameterised circular FIFO of fetch_entry_t with push, pop and synchronous flush, plus count/full/empty outputs.
- `fetch_unit` itself holds the PC register, the push/redirect logic and the `rom_addr` mapping.

## Test plan
- Reset then free-run, with the ROM model loaded as word0=32'h002080B3 and word1=32'h40208033, inst_ready=1:
  - cycle 1: inst=32'h002080B3, inst_pc=0;
  - cycle 2: inst=32'h40208033, inst_pc=4;
  - rom_addr increments by 1 per cycle.
- Stall with inst_ready=0 for 5 cycles from reset:
  - queue fills to QDEPTH=2 and pc stops at 8 (rom_addr=2);
  - on release, inst_pc sequence is 0, 4, 8 with no gaps or duplicates.
- Full queue and pop in the same cycle: count stays at 2, pc advances by 4, and the entry order is preserved.
- Redirect to 32'h0000_0022 while the queue holds 2 entries:
  - next cycle inst_valid=0 and rom_addr=8;
  - the following cycle inst_pc=32'h20.
- Wrap: with RESET_PC=32'hFFFF_FFFC, the second fetched inst_pc is 0 and rom_addr is 0.
- Assert rst mid-stream with the queue holding 1 entry:
  - inst_valid=0 immediately and pc=RESET_PC;
  - after release, the fetch restarts at RESET_PC.
